mt_op_seq: RTL
==============

MT_OP_SEQ -- requirements
Module: mt_op_seq

Interface
REQ-001 Parameter TIMEOUT, default 24'd1000000, RUN-state cycle limit before operation-incomplete.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mtINIT  input  1  MT initialize; same effect as rst.
REQ-005 mtGO  input  1  one-cycle strobe: execute function on mtFUN.
REQ-006 mtFUN  input  6  function code, valid with mtGO.
REQ-007 mtFCWR  input  1  one-cycle frame-counter write strobe.
REQ-008 mtFCIN  input  16  frame-counter write data.
REQ-009 mtONLINE  input  1  selected drive online and ready.
REQ-010 mtFRAME  input  1  one-cycle strobe per data frame passed.
REQ-011 mtREC  input  1  one-cycle strobe per record spaced.
REQ-012 mtEOR  input  1  one-cycle end-of-record strobe.
REQ-013 mtFC  output  16  frame counter value.
REQ-014 mtBUSY  output  1  operation in progress.
REQ-015 mtDONE  output  1  one-cycle completion pulse (attention source).
REQ-016 mtSETILF, mtSETNEF, mtSETRMR, mtSETFCE, mtSETOPI  output  1 each  one-cycle error-set pulses to the MT error register.

Function
REQ-017 States: IDLE, RUN, DONE; encoding free; mtBUSY = 1 in RUN and DONE only.
REQ-018 Legal codes: 6'o00 NOP, 6'o14 SPCFWD, 6'o15 SPCREV, 6'o30 WRFWD, 6'o34 RDFWD; all others illegal.
REQ-019 IDLE, mtGO with illegal code: mtSETILF pulses next cycle, state stays IDLE, mtFC unchanged.
REQ-020 IDLE, mtGO with NOP: next state DONE regardless of mtONLINE.
REQ-021 IDLE, mtGO with non-NOP legal code and mtONLINE=0: mtSETNEF pulses next cycle, stays IDLE.
REQ-022 IDLE, mtGO with non-NOP legal code and mtONLINE=1: function latched, next state RUN, timeout counter cleared.
REQ-023 RUN, SPCFWD/SPCREV: each mtREC increments mtFC mod 2^16; the increment producing 16'h0000 moves to DONE.
REQ-024 RUN, WRFWD/RDFWD: each mtFRAME increments mtFC mod 2^16; mtREC ignored.
REQ-025 RUN, WRFWD/RDFWD: mtEOR moves to DONE; WRFWD with mtFC != 0 on that cycle (after any same-cycle increment) also pulses mtSETFCE; RDFWD never sets FCE.
REQ-026 RUN, mtONLINE falling to 0: mtSETNEF pulse, move to DONE.
REQ-027 DONE lasts exactly one cycle with mtDONE=1, then IDLE.
REQ-028 All error pulses and mtDONE are registered, high exactly one cycle.
REQ-029 mtFCWR in IDLE loads mtFCIN into mtFC next cycle; in RUN/DONE write is ignored and mtSETRMR pulses.
REQ-030 mtGO in RUN/DONE: ignored, mtSETRMR pulses; mtGO+mtFCWR both in busy state give one RMR pulse.
REQ-031 mtGO and mtFCWR same IDLE cycle: load applies first, operation counts from loaded value.
REQ-032 RUN priority per cycle: completion (REQ-023/025) > offline (REQ-026) > timeout (REQ-034).

Reset
REQ-033 rst or mtINIT, any state: next cycle IDLE, mtFC=0, mtBUSY=0, mtDONE=0, all error pulses 0, timeout counter 0; no mtDONE issued for aborted operation.

Configuration
REQ-034 Macro MT_OPI_TIMEOUT_EN defined: counter increments each RUN cycle; on reaching TIMEOUT-1 without completion, mtSETOPI pulses and state moves to DONE.
REQ-035 Macro MT_OPI_TIMEOUT_EN undefined: no timeout counter, mtSETOPI constant 0, RUN ends only per REQ-023/025/026.

Verification
REQ-036 mtFCWR 16'hFFFD, GO WRFWD online, 3 mtFRAME, mtEOR -> mtFC=0, no FCE, mtDONE one cycle, mtBUSY low after.
REQ-037 mtFCWR 16'hFFF0, GO WRFWD, 2 mtFRAME, mtEOR -> mtFC=16'hFFF2, mtSETFCE and mtDONE each one pulse.
REQ-038 GO 6'o17 -> mtSETILF one pulse, mtBUSY stays 0; GO 6'o34 with mtONLINE=0 -> mtSETNEF one pulse.
REQ-039 RUN SPCFWD at mtFC=16'hFFFE: 2 mtREC -> DONE after second; mtFCWR 16'h1234 during RUN -> mtSETRMR, mtFC unchanged.
REQ-040 With MT_OPI_TIMEOUT_EN, TIMEOUT=16, GO RDFWD, no strobes -> mtSETOPI then mtDONE 16 cycles after entering RUN; without macro, stays RUN.
REQ-041 mtINIT mid-RUN at mtFC=16'h0005 -> next cycle IDLE, mtFC=0, no mtDONE.

Source files
------------

// File: rtl/mt_op_seq.sv
// mt_op_seq: magnetic-tape operation sequencer. It accepts a function strobe,
// runs space/write/read operations against the drive strobes, and keeps the
// frame counter. It issues a completion pulse and one-cycle error-set pulses.
// Optional feature: define MT_OPI_TIMEOUT_EN to enable the RUN-state timeout
// that raises mtSETOPI.
module mt_op_seq #(
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtINIT,
  input  logic        mtGO,
  input  logic [5:0]  mtFUN,
  input  logic        mtFCWR,
  input  logic [15:0] mtFCIN,
  input  logic        mtONLINE,
  input  logic        mtFRAME,
  input  logic        mtREC,
  input  logic        mtEOR,
  output logic [15:0] mtFC,
  output logic        mtBUSY,
  output logic        mtDONE,
  output logic        mtSETILF,
  output logic        mtSETNEF,
  output logic        mtSETRMR,
  output logic        mtSETFCE,
  output logic        mtSETOPI
);

  localparam int unsigned FC_W  = 16;
  localparam int unsigned FUN_W = 6;

  localparam logic [FUN_W-1:0] FUN_NOP    = 6'o00;
  localparam logic [FUN_W-1:0] FUN_SPCFWD = 6'o14;
  localparam logic [FUN_W-1:0] FUN_SPCREV = 6'o15;
  localparam logic [FUN_W-1:0] FUN_WRFWD  = 6'o30;
  localparam logic [FUN_W-1:0] FUN_RDFWD  = 6'o34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [FUN_W-1:0] func_q, func_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ilf_q, ilf_d;
  logic             nef_q, nef_d;
  logic             rmr_q, rmr_d;
  logic             fce_q, fce_d;
  logic [FC_W-1:0]  fc_inc;
  logic             fun_legal;
  logic             is_spc;
  logic             done_ev;

`ifdef MT_OPI_TIMEOUT_EN
  logic [23:0]      cnt_q, cnt_d;
  logic             opi_q, opi_d;
`else
  logic             unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign fc_inc    = fc_q + FC_W'(1);
  assign fun_legal = (mtFUN == FUN_NOP)   || (mtFUN == FUN_SPCFWD) ||
                     (mtFUN == FUN_SPCREV) || (mtFUN == FUN_WRFWD)  ||
                     (mtFUN == FUN_RDFWD);
  assign is_spc    = (func_q == FUN_SPCFWD) || (func_q == FUN_SPCREV);

  // Next-state, frame-counter and pulse decode.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    func_d  = func_q;
    ilf_d   = 1'b0;
    nef_d   = 1'b0;
    rmr_d   = 1'b0;
    fce_d   = 1'b0;
    done_ev = 1'b0;
`ifdef MT_OPI_TIMEOUT_EN
    cnt_d   = cnt_q;
    opi_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle counter load lands before the operation starts counting.
        if (mtFCWR) fc_d = mtFCIN;
        if (mtGO) begin
          if (!fun_legal) begin
            ilf_d = 1'b1;
          end else if (mtFUN == FUN_NOP) begin
            state_d = ST_DONE;
          end else if (!mtONLINE) begin
            nef_d = 1'b1;
          end else begin
            func_d  = mtFUN;
            state_d = ST_RUN;
`ifdef MT_OPI_TIMEOUT_EN
            cnt_d   = 24'd0;
`endif
          end
        end
      end
      ST_RUN: begin
        rmr_d = mtGO | mtFCWR;
        if (is_spc) begin
          if (mtREC) begin
            fc_d = fc_inc;
            if (fc_inc == FC_W'(0)) done_ev = 1'b1;
          end
        end else begin
          if (mtFRAME) fc_d = fc_inc;
          if (mtEOR) begin
            done_ev = 1'b1;
            if ((func_q == FUN_WRFWD) && (fc_d != FC_W'(0))) fce_d = 1'b1;
          end
        end
`ifdef MT_OPI_TIMEOUT_EN
        cnt_d = cnt_q + 24'd1;
`endif
        // Completion outranks drive-offline, which outranks timeout.
        if (done_ev) begin
          state_d = ST_DONE;
        end else if (!mtONLINE) begin
          nef_d   = 1'b1;
          state_d = ST_DONE;
        end
`ifdef MT_OPI_TIMEOUT_EN
        else if (cnt_q == (TIMEOUT - 24'd1)) begin
          opi_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        rmr_d   = mtGO | mtFCWR;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; rst and mtINIT both force a clean idle.
  always_ff @(posedge clk) begin
    if (rst || mtINIT) begin
      state_q <= ST_IDLE;
      fc_q    <= '0;
      func_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ilf_q   <= 1'b0;
      nef_q   <= 1'b0;
      rmr_q   <= 1'b0;
      fce_q   <= 1'b0;
`ifdef MT_OPI_TIMEOUT_EN
      cnt_q   <= '0;
      opi_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      func_q  <= func_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ilf_q   <= ilf_d;
      nef_q   <= nef_d;
      rmr_q   <= rmr_d;
      fce_q   <= fce_d;
`ifdef MT_OPI_TIMEOUT_EN
      cnt_q   <= cnt_d;
      opi_q   <= opi_d;
`endif
    end
  end

  assign mtFC     = fc_q;
  assign mtBUSY   = busy_q;
  assign mtDONE   = done_q;
  assign mtSETILF = ilf_q;
  assign mtSETNEF = nef_q;
  assign mtSETRMR = rmr_q;
  assign mtSETFCE = fce_q;
`ifdef MT_OPI_TIMEOUT_EN
  assign mtSETOPI = opi_q;
`else
  assign mtSETOPI = 1'b0;
`endif

endmodule
